// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO_SYNC write port among N requesters.
// An owner keeps the port for up to BURST consecutive grants before the pointer rotates.
module fifo_wr_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int BURST = 4,
   localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [N-1:0]          REQ,
   input  logic [N*WIDTH-1:0]    WDATA,
   output logic [N-1:0]          GNT,
   input  logic                  FIFO_FULL,
   output logic                  FIFO_WRITE,
   output logic [IDW+WIDTH-1:0]  FIFO_WDATA,
   output logic [IDW-1:0]        OWNER
);

   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   logic [0:0]     state_reg, state_next;
   logic [IDW-1:0] ptr_reg, ptr_next;
   logic [IDW-1:0] owner_reg, owner_next;
   logic [CW-1:0]  cnt_reg, cnt_next;

   logic [WIDTH-1:0] slice [N];
   logic [IDW-1:0]   rot [N];
   logic [N-1:0]     req_rot;
   logic [IDW-1:0]   base;
   logic [IDW-1:0]   owner_inc;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   win_inc;
   logic             found;
   logic             grant;
   logic [IDW-1:0]   gnt_idx;
   logic [CW-1:0]    cnt_inc;

   assign owner_inc = (owner_reg == IDW'(N - 1)) ? '0 : owner_reg + 1'b1;
   assign win_inc   = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
   assign cnt_inc   = cnt_reg + 1'b1;

   // A dropped owner hands the scan to the next index in the same cycle (no bubble).
   assign base = (state_reg == OWN) ? owner_inc : ptr_reg;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_req
         logic [IDW:0] sum;
         assign slice[gi]   = WDATA[gi*WIDTH +: WIDTH];
         assign sum         = {1'b0, base} + (IDW+1)'(gi);
         assign rot[gi]     = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
         assign req_rot[gi] = REQ[rot[gi]];
      end
   endgenerate

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found = 1'b1;
            win   = rot[k];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      owner_next = owner_reg;
      cnt_next   = cnt_reg;
      grant      = 1'b0;
      gnt_idx    = '0;
      if (state_reg == OWN && REQ[owner_reg]) begin
         // Owner still requesting: grant unless full; a full FIFO simply stalls the burst.
         if (!FIFO_FULL) begin
            grant    = 1'b1;
            gnt_idx  = owner_reg;
            cnt_next = cnt_inc;
            if (cnt_inc == BURST_C) begin
               state_next = IDLE;
               ptr_next   = owner_inc;
            end
         end
      end else begin
         if (state_reg == OWN) begin
            state_next = IDLE;
            ptr_next   = owner_inc;
         end
         if (found && !FIFO_FULL) begin
            grant      = 1'b1;
            gnt_idx    = win;
            owner_next = win;
            cnt_next   = CW'(1);
            if (BURST == 1) begin
               state_next = IDLE;
               ptr_next   = win_inc;
            end else begin
               state_next = OWN;
            end
         end
      end
   end

   always_comb begin
      GNT = '0;
      for (int k = 0; k < N; k++) begin
         GNT[k] = grant && (gnt_idx == IDW'(k));
      end
   end

   assign FIFO_WRITE = grant;
   assign FIFO_WDATA = grant ? {gnt_idx, slice[gnt_idx]} : '0;
   assign OWNER      = owner_reg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         owner_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         owner_reg <= owner_next;
         cnt_reg   <= cnt_next;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized FIFO loop checked
// against a rule-level reference model and per-source ordering scoreboard.
module tb_fifo_wr_arbiter;

   localparam int N = 4, WIDTH = 8, BURST = 4, IDW = 2;

   logic                 CLK = 1'b0;
   logic                 RESET;
   logic [N-1:0]         req;
   logic [N*WIDTH-1:0]   wdata;
   logic                 full;
   logic [N-1:0]         gnt;
   logic                 fifo_write;
   logic [IDW+WIDTH-1:0] fifo_wdata;
   logic [IDW-1:0]       owner;

   logic [2:0]   req3;
   logic [23:0]  wdata3;
   logic         full3;
   logic [2:0]   gnt3;
   logic         write3;
   logic [9:0]   fw3;
   logic [1:0]   owner3;

   int n_cmp = 0;
   int n_bad = 0;

   bit m_owning;
   int m_ptr, m_owner, m_cnt;

   fifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(req), .WDATA(wdata), .GNT(gnt),
      .FIFO_FULL(full), .FIFO_WRITE(fifo_write), .FIFO_WDATA(fifo_wdata), .OWNER(owner)
   );

   fifo_wr_arbiter #(.N(3), .WIDTH(8), .BURST(2)) dut3 (
      .CLK(CLK), .RESET(RESET), .REQ(req3), .WDATA(wdata3), .GNT(gnt3),
      .FIFO_FULL(full3), .FIFO_WRITE(write3), .FIFO_WDATA(fw3), .OWNER(owner3)
   );

   always #5 CLK = ~CLK;

   // Reference: who gets the port this cycle, or -1.
   function automatic int model_grant(input logic [N-1:0] r, input logic f);
      int from;
      if (m_owning && r[m_owner]) return f ? -1 : m_owner;
      if (f) return -1;
      from = m_owning ? (m_owner + 1) % N : m_ptr;
      for (int k = 0; k < N; k++) if (r[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction

   task automatic model_commit(input logic [N-1:0] r, input logic f);
      int g;
      g = model_grant(r, f);
      if (m_owning && r[m_owner]) begin
         if (g >= 0) begin
            m_cnt++;
            if (m_cnt == BURST) begin
               m_owning = 0;
               m_ptr    = (m_owner + 1) % N;
            end
         end
      end else begin
         if (m_owning) begin
            m_owning = 0;
            m_ptr    = (m_owner + 1) % N;
         end
         if (g >= 0) begin
            m_owner = g;
            m_cnt   = 1;
            if (BURST == 1) m_ptr = (g + 1) % N;
            else m_owning = 1;
         end
      end
   endtask

   function automatic logic [N-1:0] onehot(input int g);
      logic [N-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   function automatic logic [IDW+WIDTH-1:0] exp_word(input int g);
      if (g < 0) return '0;
      return {IDW'(g), wdata[g*WIDTH +: WIDTH]};
   endfunction

   task automatic tick();
      model_commit(req, full);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      req = '0; req3 = '0; full = 1'b0; full3 = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      m_owning = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      req = '0; req3 = '0; full = 1'b0; full3 = 1'b0; wdata = '0; wdata3 = '0;
      #3;
      n_cmp++;
      if (gnt !== '0 || fifo_write !== 1'b0 || fifo_wdata !== '0 || owner !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: gnt=%b write=%b wdata=%h owner=%0d, required 0", gnt, fifo_write, fifo_wdata, owner);
      end
      do_reset();
      req = 4'b1000;
      wdata = {N*WIDTH{1'b0}} | 32'h5A000000;
      @(negedge CLK);
      n_cmp++;
      if (gnt !== 4'b1000 || fifo_wdata !== {2'd3, 8'h5A}) begin
         n_bad++;
         $display("FAIL reset_first_grant: gnt=%b wdata=%h, required 1000 / 35a", gnt, fifo_wdata);
      end
      tick();
   endtask

   task automatic test_single_source();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         req = 4'b0001;
         wdata = '0;
         wdata[7:0] = 8'(c);
         @(negedge CLK);
         n_cmp++;
         if (gnt !== 4'b0001 || fifo_write !== 1'b1 || fifo_wdata !== {2'd0, 8'(c)}) begin
            n_bad++;
            $display("FAIL single_src c%0d: gnt=%b write=%b wdata=%h, required 0001/1/%h", c, gnt, fifo_write, fifo_wdata, {2'd0, 8'(c)});
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         req = 4'b1111;
         wdata = {$urandom, $urandom} >> 32;
         wdata = $urandom;
         @(negedge CLK);
         n_cmp++;
         if (gnt !== onehot((c / BURST) % N) || fifo_write !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_order c%0d: gnt=%b write=%b, required %b/1", c, gnt, fifo_write, onehot((c / BURST) % N));
         end
         n_cmp++;
         if (fifo_wdata !== exp_word(model_grant(req, full))) begin
            n_bad++;
            $display("FAIL rr_wdata c%0d: wdata=%h, required %h", c, fifo_wdata, exp_word(model_grant(req, full)));
         end
         tick();
      end
   endtask

   task automatic test_owner_drop();
      logic [N-1:0] r [7] = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
      int           e [7] = '{0, 0, 1, 1, 1, 1, 0};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         req = r[c];
         wdata = $urandom;
         @(negedge CLK);
         n_cmp++;
         if (gnt !== onehot(e[c]) || fifo_wdata !== exp_word(e[c])) begin
            n_bad++;
            $display("FAIL owner_drop c%0d: gnt=%b wdata=%h, required %b/%h", c, gnt, fifo_wdata, onehot(e[c]), exp_word(e[c]));
         end
         if (c == 3) begin
            n_cmp++;
            if (owner !== 2'd1) begin
               n_bad++;
               $display("FAIL owner_after_drop: owner=%0d, required 1", owner);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic f [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
      int   e [9] = '{0, 0, -1, -1, -1, 0, 0, 1, 1};
      do_reset();
      for (int c = 0; c < 9; c++) begin
         req = 4'b1111;
         full = f[c];
         wdata = $urandom;
         @(negedge CLK);
         n_cmp++;
         if (gnt !== onehot(e[c]) || fifo_write !== (e[c] >= 0) || fifo_wdata !== exp_word(e[c])) begin
            n_bad++;
            $display("FAIL backpressure c%0d: gnt=%b write=%b wdata=%h, required %b/%h", c, gnt, fifo_write, fifo_wdata, onehot(e[c]), exp_word(e[c]));
         end
         tick();
      end
      full = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req = 4'b0100;
         tick();
      end
      n_cmp++;
      if (owner !== 2'd2) begin
         n_bad++;
         $display("FAIL mid_burst_owner: owner=%0d, required 2", owner);
      end
      #2;
      RESET = 1'b1;
      req = '0;
      #1;
      n_cmp++;
      if (owner !== '0) begin
         n_bad++;
         $display("FAIL async_reset_owner: owner=%0d, required 0", owner);
      end
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      m_owning = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      req = 4'b0110;
      wdata = $urandom;
      @(negedge CLK);
      n_cmp++;
      if (gnt !== 4'b0010 || fifo_wdata !== exp_word(1)) begin
         n_bad++;
         $display("FAIL post_reset_grant: gnt=%b wdata=%h, required 0010/%h", gnt, fifo_wdata, exp_word(1));
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [2:0] r [6] = '{3'b010, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
      int         e [6] = '{1, 2, 2, 0, 0, 2};
      logic [2:0] eg;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         req3 = r[c];
         wdata3 = 24'($urandom);
         @(negedge CLK);
         eg = '0;
         eg[e[c]] = 1'b1;
         n_cmp++;
         if (gnt3 !== eg || write3 !== 1'b1 || fw3 !== {2'(e[c]), wdata3[e[c]*8 +: 8]}) begin
            n_bad++;
            $display("FAIL wrap c%0d: gnt=%b fw=%h, required %b/%h", c, gnt3, fw3, eg, {2'(e[c]), wdata3[e[c]*8 +: 8]});
         end
         @(posedge CLK);
         #1;
      end
      req3 = '0;
   endtask

   task automatic test_random_fifo_loop();
      bit                   pend [N];
      int                   seq [N];
      int                   exp_pop [N];
      logic [IDW+WIDTH-1:0] fq [$];
      logic [IDW+WIDTH-1:0] w;
      logic [N-1:0]         gl;
      int                   popped, cycles, g, t;
      do_reset();
      for (int s = 0; s < N; s++) begin
         pend[s] = 0; seq[s] = 0; exp_pop[s] = 0;
      end
      popped = 0;
      cycles = 0;
      while (popped < 256 && cycles < 6000) begin
         for (int s = 0; s < N; s++) begin
            if (pend[s] && $urandom_range(15) == 0) pend[s] = 0;
            else if (!pend[s] && $urandom_range(1) == 1) pend[s] = 1;
            req[s] = pend[s];
            wdata[s*WIDTH +: WIDTH] = 8'(seq[s]);
         end
         full = (fq.size() >= 2);
         @(negedge CLK);
         g = model_grant(req, full);
         n_cmp++;
         if (gnt !== onehot(g) || fifo_wdata !== exp_word(g)) begin
            n_bad++;
            $display("FAIL rand_grant cyc%0d: gnt=%b wdata=%h, required %b/%h", cycles, gnt, fifo_wdata, onehot(g), exp_word(g));
         end
         n_cmp++;
         if (fifo_write && full) begin
            n_bad++;
            $display("FAIL write_while_full cyc%0d: write=1, required 0", cycles);
         end
         gl = gnt;
         if (fq.size() > 0) begin
            w = fq.pop_front();
            t = int'(w[IDW+WIDTH-1:WIDTH]);
            n_cmp++;
            if (w[WIDTH-1:0] !== 8'(exp_pop[t])) begin
               n_bad++;
               $display("FAIL order src%0d: payload=%h, required %h", t, w[WIDTH-1:0], 8'(exp_pop[t]));
            end
            exp_pop[t]++;
            popped++;
         end
         if (fifo_write && !full) fq.push_back(fifo_wdata);
         tick();
         for (int s = 0; s < N; s++) begin
            if (gl[s]) begin
               pend[s] = 0;
               seq[s]++;
            end
         end
         cycles++;
      end
      n_cmp++;
      if (popped < 256) begin
         n_bad++;
         $display("FAIL loop_timeout: popped=%0d, required 256", popped);
      end
      req = '0;
      full = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_owner_drop();
      test_backpressure();
      test_reset_mid_burst();
      test_wrap();
      test_random_fifo_loop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
